// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and its stall/flush/trap sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a; request side drives levels, controller side answers the same cycle.
interface pipeline_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_SRC    = 4,
    parameter int EXC_W      = 3,
    parameter int CNT_W      = 32
);
    // requests from the pipeline
    logic [NUM_SRC-1:0]       stall_req;
    logic                     branch_taken;
    logic                     exc_valid;
    logic [EXC_W-1:0]         exc_code;
    logic                     perf_clear;
    // controls back to the pipeline registers and fetch
    logic [NUM_STAGES-1:0]    stall_out;
    logic [NUM_STAGES-1:0]    bubble_out;
    logic                     any_stall;
    logic                     pc_redirect;
    logic                     trap_redirect;
    logic [EXC_W-1:0]         trap_code;
    logic                     busy;
    logic [NUM_SRC*CNT_W-1:0] stall_cnt;

    modport master (
        output stall_req, branch_taken, exc_valid, exc_code, perf_clear,
        input  stall_out, bubble_out, any_stall, pc_redirect, trap_redirect,
               trap_code, busy, stall_cnt
    );

    modport slave (
        input  stall_req, branch_taken, exc_valid, exc_code, perf_clear,
        output stall_out, bubble_out, any_stall, pc_redirect, trap_redirect,
               trap_code, busy, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_unit.sv
// Stall/flush/trap sequencer: merges stall sources into hold/bubble vectors, runs RUN/DRAIN/REDIRECT for traps.
// Latency: hold/bubble/pc_redirect combinational; trap_redirect registered, issued 1 + drain cycles after the exception.
// Backpressure: older stall sources defer branches/exceptions and freeze the drain count; requests are levels.
module pipeline_ctrl_unit #(
    parameter int                 NUM_STAGES   = 5,
    parameter int                 NUM_SRC      = 4,
    parameter logic [NUM_SRC*3-1:0] SRC_STAGE  = {3'd3, 3'd2, 3'd1, 3'd0},
    parameter int                 BRANCH_STAGE = 1,
    parameter int                 EXC_STAGE    = 3,
    parameter int                 EXC_W        = 3,
    parameter int                 CNT_W        = 32
) (
    input  logic           clock_i,
    input  logic           reset_i,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_REDIR} state_t;

    // cycles the younger side stays bubbled while instructions older than the trap retire
    localparam logic [3:0] DRAIN_CYC = 4'(NUM_STAGES - 1 - EXC_STAGE);

    state_t                 state_q, state_d;
    logic [3:0]             drain_q, drain_d;
    logic [EXC_W-1:0]       trap_code_q;
    logic                   trap_redir_q;
    logic [CNT_W-1:0]       cnt_q [NUM_SRC];

    logic                   act_any;
    logic                   older_exc;
    logic                   blk_br;
    logic [2:0]             hs;
    logic [NUM_STAGES-1:0]  hold_stall, hold_bubble;
    logic                   exc_take, br_take;
    logic [NUM_STAGES-1:0]  stall_d, bubble_d;
    logic                   pc_redir_d;

    // Decode active sources: highest stalling stage and whether anything blocks a branch or trap
    always_comb begin
        act_any   = 1'b0;
        older_exc = 1'b0;
        blk_br    = 1'b0;
        hs        = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.stall_req[k]) begin
                act_any = 1'b1;
                if (SRC_STAGE[3*k +: 3] > hs) hs = SRC_STAGE[3*k +: 3];
                if (int'(SRC_STAGE[3*k +: 3]) > EXC_STAGE)     older_exc = 1'b1;
                if (int'(SRC_STAGE[3*k +: 3]) >= BRANCH_STAGE) blk_br    = 1'b1;
            end
        end
        hold_stall  = '0;
        hold_bubble = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i <= int'(hs))     hold_stall[i]  = 1'b1;
            if (i == int'(hs) + 1) hold_bubble[i] = 1'b1;
        end
        // exception outranks a branch in the same cycle
        exc_take = (state_q == S_RUN) && bus.exc_valid && !older_exc;
        br_take  = (state_q == S_RUN) && bus.branch_taken && !blk_br && !exc_take;
    end

    // State register plus trap bookkeeping
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_RUN;
            drain_q      <= 4'd0;
            trap_code_q  <= '0;
            trap_redir_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            trap_redir_q <= (state_d == S_REDIR);
            if (exc_take) trap_code_q <= bus.exc_code;
        end
    end

    // Next state: drain counts down only while no older source holds the back end
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_RUN: begin
                if (exc_take) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_CYC;
                end
            end
            S_DRAIN: begin
                if (!older_exc) begin
                    if (drain_q <= 4'd1) state_d = S_REDIR;
                    else                 drain_d = drain_q - 4'd1;
                end
            end
            S_REDIR: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Outputs: hold/bubble vectors and branch redirect for the current state
    always_comb begin
        stall_d    = '0;
        bubble_d   = '0;
        pc_redir_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (exc_take) begin
                    // kill everything from ID through the excepting instruction
                    for (int i = 1; i < NUM_STAGES; i++)
                        if (i <= EXC_STAGE + 1) bubble_d[i] = 1'b1;
                end else if (br_take) begin
                    // younger stalls are moot: their instructions are being squashed
                    pc_redir_d = 1'b1;
                    for (int i = 1; i < NUM_STAGES; i++)
                        if (i <= BRANCH_STAGE) bubble_d[i] = 1'b1;
                end else if (act_any) begin
                    stall_d  = hold_stall;
                    bubble_d = hold_bubble;
                end
            end
            S_DRAIN: begin
                if (older_exc) begin
                    stall_d  = hold_stall;
                    bubble_d = hold_bubble;
                end else begin
                    stall_d[0]  = 1'b1;
                    bubble_d[1] = 1'b1;
                end
            end
            S_REDIR: stall_d[0] = 1'b1;
            default: stall_d    = '0;
        endcase
    end

    // Saturating per-source stall counters; clear wins over increment
    always_ff @(posedge clock_i) begin
        if (reset_i || bus.perf_clear) begin
            for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++)
                if (bus.stall_req[k] && (cnt_q[k] != {CNT_W{1'b1}}))
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
        assign bus.stall_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end

    assign bus.stall_out     = stall_d;
    assign bus.bubble_out    = bubble_d;
    assign bus.any_stall     = |stall_d;
    assign bus.pc_redirect   = pc_redir_d;
    assign bus.trap_redirect = trap_redir_q;
    assign bus.trap_code     = trap_code_q;
    assign bus.busy          = (state_q != S_RUN);

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit: vector table for RUN-state decode plus trap/branch sequences.
// Latency: checks taken 1 time unit after inputs change, before the next rising edge.
// Backpressure: n/a.
module tb_pipeline_ctrl_unit;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   m_cnt [4];

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.NUM_STAGES(5), .NUM_SRC(4), .EXC_W(3), .CNT_W(CW)) bus ();

    pipeline_ctrl_unit #(.CNT_W(CW)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    // reference counter model: saturating, clear has priority
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst || bus.perf_clear)                  m_cnt[k] = 0;
            else if (bus.stall_req[k] && m_cnt[k] < 15) m_cnt[k] = m_cnt[k] + 1;
        end
    end

    typedef struct {
        logic [3:0] req;
        logic       br;
        logic [4:0] st;
        logic [4:0] bb;
        logic       pc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic br, input logic exc,
                         input logic [2:0] code, input logic clr);
        @(negedge clk);
        bus.stall_req    = req;
        bus.branch_taken = br;
        bus.exc_valid    = exc;
        bus.exc_code     = code;
        bus.perf_clear   = clr;
        #1;
    endtask

    task automatic chk_ctl(input string name, input logic [4:0] st, input logic [4:0] bb,
                           input logic pc, input logic busy);
        chk({name, ".stall"},  32'(bus.stall_out),   32'(st));
        chk({name, ".bubble"}, 32'(bus.bubble_out),  32'(bb));
        chk({name, ".any"},    32'(bus.any_stall),   32'(|st));
        chk({name, ".pc"},     32'(bus.pc_redirect), 32'(pc));
        chk({name, ".busy"},   32'(bus.busy),        32'(busy));
    endtask

    function automatic logic [3:0] cnt_of(input int k);
        return bus.stall_cnt[k*CW +: CW];
    endfunction

    initial begin
        //          req      br    stall     bubble    pc
        tbl[0]  = '{4'b0010, 1'b0, 5'b00011, 5'b00100, 1'b0};
        tbl[1]  = '{4'b1010, 1'b0, 5'b01111, 5'b10000, 1'b0};
        tbl[2]  = '{4'b0001, 1'b0, 5'b00001, 5'b00010, 1'b0};
        tbl[3]  = '{4'b0100, 1'b0, 5'b00111, 5'b01000, 1'b0};
        tbl[4]  = '{4'b1000, 1'b0, 5'b01111, 5'b10000, 1'b0};
        tbl[5]  = '{4'b1111, 1'b0, 5'b01111, 5'b10000, 1'b0};
        tbl[6]  = '{4'b0101, 1'b0, 5'b00111, 5'b01000, 1'b0};
        tbl[7]  = '{4'b0001, 1'b1, 5'b00000, 5'b00010, 1'b1};
        tbl[8]  = '{4'b0000, 1'b1, 5'b00000, 5'b00010, 1'b1};
        tbl[9]  = '{4'b0010, 1'b1, 5'b00011, 5'b00100, 1'b0};
        tbl[10] = '{4'b0100, 1'b1, 5'b00111, 5'b01000, 1'b0};
        tbl[11] = '{4'b0000, 1'b0, 5'b00000, 5'b00000, 1'b0};

        rst = 1'b1;
        bus.stall_req = '0; bus.branch_taken = 0; bus.exc_valid = 0;
        bus.exc_code = '0; bus.perf_clear = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        repeat (10) drive(4'b0000, 0, 0, 3'd0, 0);
        chk_ctl("idle", 5'b0, 5'b0, 1'b0, 1'b0);
        chk("idle.trap_redirect", 32'(bus.trap_redirect), 32'd0);
        chk("idle.trap_code",     32'(bus.trap_code),     32'd0);
        chk("idle.stall_cnt",     32'(bus.stall_cnt),     32'd0);

        // load-use stall held three cycles
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 0, 0, 3'd0, 0);
            chk_ctl("loaduse", 5'b00011, 5'b00100, 1'b0, 1'b0);
        end
        drive(4'b0000, 0, 0, 3'd0, 0);
        chk("loaduse.cnt1", 32'(cnt_of(1)), 32'd3);

        // RUN-state decode table
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].req, tbl[i].br, 0, 3'd0, 0);
            chk_ctl($sformatf("vec%0d", i), tbl[i].st, tbl[i].bb, tbl[i].pc, 1'b0);
        end

        // branch blocked by EX stall, accepted once the stall drops
        drive(4'b0100, 1, 0, 3'd0, 0);
        chk("br_held.pc", 32'(bus.pc_redirect), 32'd0);
        drive(4'b0000, 1, 0, 3'd0, 0);
        chk_ctl("br_go", 5'b00000, 5'b00010, 1'b1, 1'b0);

        // precise trap: accept, drain one cycle, redirect, back to RUN
        drive(4'b0000, 0, 1, 3'd5, 0);
        chk_ctl("exc", 5'b00000, 5'b11110, 1'b0, 1'b0);
        drive(4'b0000, 1, 1, 3'd2, 0);      // branch and exception ignored while draining
        chk_ctl("drain", 5'b00001, 5'b00010, 1'b0, 1'b1);
        chk("drain.trap_redirect", 32'(bus.trap_redirect), 32'd0);
        drive(4'b0000, 0, 0, 3'd0, 0);
        chk_ctl("redir", 5'b00001, 5'b00000, 1'b0, 1'b1);
        chk("redir.trap_redirect", 32'(bus.trap_redirect), 32'd1);
        chk("redir.trap_code",     32'(bus.trap_code),     32'd5);
        drive(4'b0000, 0, 0, 3'd0, 0);
        chk_ctl("run_again", 5'b0, 5'b0, 1'b0, 1'b0);
        chk("run_again.trap_redirect", 32'(bus.trap_redirect), 32'd0);
        chk("run_again.trap_code",     32'(bus.trap_code),     32'd5);

        // exception beats a branch and a younger stall in the same cycle
        drive(4'b0001, 1, 1, 3'd6, 0);
        chk_ctl("exc_wins", 5'b00000, 5'b11110, 1'b0, 1'b0);
        drive(4'b0000, 0, 0, 3'd0, 0);
        drive(4'b0000, 0, 0, 3'd0, 0);
        chk("exc_wins.trap_code",     32'(bus.trap_code),     32'd6);
        chk("exc_wins.trap_redirect", 32'(bus.trap_redirect), 32'd1);

        // reset while draining: straight back to RUN, no trap redirect
        drive(4'b0000, 0, 0, 3'd0, 0);
        drive(4'b0000, 0, 1, 3'd3, 0);
        drive(4'b0000, 0, 0, 3'd0, 0);
        chk("rst_drain.busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        drive(4'b0000, 0, 0, 3'd0, 0);
        rst = 1'b0;
        chk("rst_drain.busy_after",  32'(bus.busy),          32'd0);
        chk("rst_drain.trap_redir",  32'(bus.trap_redirect), 32'd0);
        chk("rst_drain.trap_code",   32'(bus.trap_code),     32'd0);
        drive(4'b0000, 0, 0, 3'd0, 0);
        chk("rst_drain.trap_redir2", 32'(bus.trap_redirect), 32'd0);

        // counter saturation and clear priority
        repeat (20) drive(4'b0001, 0, 0, 3'd0, 0);
        drive(4'b0001, 0, 0, 3'd0, 1);
        chk("sat.cnt0", 32'(cnt_of(0)), 32'd15);
        drive(4'b0000, 0, 0, 3'd0, 0);
        chk("clr.cnt0", 32'(cnt_of(0)), 32'd0);

        for (int k = 0; k < 4; k++)
            chk($sformatf("final.cnt%0d", k), 32'(cnt_of(k)), 32'(m_cnt[k]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
